// File: rtl/uart_tx_fifo_if.sv
// Push/pop bus between the APB register block, the transmit FIFO and the UART transmitter.
// The master side pushes and pops; the slave side is the FIFO itself.
interface uart_tx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  fifo_write_n;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  fifo_read_n;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  fifo_afull;
  logic [ADDR_WIDTH:0]   fifo_count;
  logic                  overflow;
  logic                  clr_overflow;

  modport master (
    output fifo_write_n, data_in, fifo_read_n, clr_overflow,
    input  data_out, fifo_empty, fifo_full, fifo_afull, fifo_count, overflow
  );

  modport slave (
    input  fifo_write_n, data_in, fifo_read_n, clr_overflow,
    output data_out, fifo_empty, fifo_full, fifo_afull, fifo_count, overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit FIFO for the UART: registered pop data, count-decoded status flags
// and a sticky overflow flag.
module uart_tx_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int AFULL_LEVEL = 12
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_fifo_if.slave    bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_nxt;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  overflow_q;

  logic push_req;
  logic pop_req;
  logic push_ok;
  logic pop_ok;
  logic empty;
  logic full;
  logic ovf_set;

  assign push_req = ~bus.fifo_write_n;
  assign pop_req  = ~bus.fifo_read_n;

  // Flags decode the registered count only, so pointer wrap never glitches them.
  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

  // A push into a full FIFO still lands when a pop frees the slot in the same cycle.
  assign pop_ok   = pop_req && !empty;
  assign push_ok  = push_req && (!full || pop_ok);
  assign ovf_set  = push_req && !push_ok;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned
  // and a latch is never inferred.
  always_comb begin
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; a same-slot read and write on a full push+pop returns the old byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_out_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      count <= count_nxt;
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr     <= rd_ptr + 1'b1;
        data_out_q <= mem[rd_ptr];
      end
      if (ovf_set) begin
        overflow_q <= 1'b1;
      end else if (bus.clr_overflow) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // NOTE: the storage array has no reset; its contents are unobservable until written,
  // and leaving it out keeps it mappable onto plain flops or RAM without a clear network.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.fifo_empty = empty;
  assign bus.fifo_full  = full;
  assign bus.fifo_afull = (count >= AFULL_C);
  assign bus.fifo_count = count;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a vector table for single-cycle behaviour plus
// hand-written fill/overflow/wrap and transmitter-hold sequences.
module tb_uart_tx_fifo;

  localparam int DW = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset;

  uart_tx_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  uart_tx_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_LEVEL(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       wr_n;
    logic [7:0] din;
    logic       rd_n;
    logic       clr;
    logic [7:0] dout;
    logic [4:0] cnt;
    logic       empty;
    logic       full;
    logic       afull;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, let the edge pass, sample 1 ns later.
  task automatic drive(input logic r, input logic wn, input logic [7:0] d,
                       input logic rn, input logic c);
    reset            = r;
    bus.fifo_write_n = wn;
    bus.data_in      = d;
    bus.fifo_read_n  = rn;
    bus.clr_overflow = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [7:0] dout, input logic [4:0] cnt,
                           input logic empty, input logic full, input logic afull,
                           input logic ovf);
    check({tag, ".data_out"}, 32'(bus.data_out), 32'(dout));
    check({tag, ".count"},    32'(bus.fifo_count), 32'(cnt));
    check({tag, ".empty"},    32'(bus.fifo_empty), 32'(empty));
    check({tag, ".full"},     32'(bus.fifo_full), 32'(full));
    check({tag, ".afull"},    32'(bus.fifo_afull), 32'(afull));
    check({tag, ".overflow"}, 32'(bus.overflow), 32'(ovf));
  endtask

  task automatic add(input logic rst, input logic wr_n, input logic [7:0] din,
                     input logic rd_n, input logic clr, input logic [7:0] dout,
                     input logic [4:0] cnt, input logic empty);
    vec_t v;
    v.rst = rst; v.wr_n = wr_n; v.din = din; v.rd_n = rd_n; v.clr = clr;
    v.dout = dout; v.cnt = cnt; v.empty = empty;
    v.full = 1'b0; v.afull = 1'b0; v.ovf = 1'b0;
    vecs.push_back(v);
  endtask

  initial begin
    reset            = 1'b1;
    bus.fifo_write_n = 1'b1;
    bus.data_in      = '0;
    bus.fifo_read_n  = 1'b1;
    bus.clr_overflow = 1'b0;

    //   rst wr_n din    rd_n clr  dout   cnt empty
    add(1, 1, 8'h00, 1, 0, 8'h00, 0, 1);   // reset state
    add(0, 0, 8'h41, 1, 0, 8'h00, 1, 0);
    add(0, 0, 8'h42, 1, 0, 8'h00, 2, 0);
    add(0, 0, 8'h43, 1, 0, 8'h00, 3, 0);
    add(0, 1, 8'h00, 0, 0, 8'h41, 2, 0);
    add(0, 1, 8'h00, 0, 0, 8'h42, 1, 0);
    add(0, 1, 8'h00, 0, 0, 8'h43, 0, 1);
    add(0, 1, 8'h00, 0, 0, 8'h43, 0, 1);   // pop on empty holds data_out
    add(1, 1, 8'h00, 1, 0, 8'h00, 0, 1);
    add(0, 0, 8'h55, 0, 0, 8'h00, 1, 0);   // push+pop on empty: no bypass
    add(0, 1, 8'h00, 0, 0, 8'h55, 0, 1);
    add(0, 0, 8'h01, 1, 0, 8'h55, 1, 0);
    add(0, 0, 8'h02, 1, 0, 8'h55, 2, 0);
    add(0, 0, 8'h03, 1, 0, 8'h55, 3, 0);
    add(0, 0, 8'h04, 1, 0, 8'h55, 4, 0);
    add(0, 0, 8'h05, 1, 0, 8'h55, 5, 0);
    add(0, 1, 8'h00, 0, 0, 8'h01, 4, 0);
    add(0, 1, 8'h00, 0, 0, 8'h02, 3, 0);
    add(1, 0, 8'h99, 1, 0, 8'h00, 0, 1);   // reset mid-burst with push strobe
    add(0, 1, 8'h00, 0, 0, 8'h00, 0, 1);   // pop after reset ignored
    add(0, 1, 8'h00, 1, 0, 8'h00, 0, 1);
    add(0, 0, 8'h3C, 1, 0, 8'h00, 1, 0);
    add(0, 1, 8'h00, 0, 0, 8'h3C, 0, 1);   // one-cycle transmitter pulse
    add(0, 1, 8'h00, 1, 0, 8'h3C, 0, 1);   // held with no strobe
    add(0, 1, 8'h00, 1, 0, 8'h3C, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].wr_n, vecs[i].din, vecs[i].rd_n, vecs[i].clr);
      check_all($sformatf("vec%0d", i), vecs[i].dout, vecs[i].cnt, vecs[i].empty,
                vecs[i].full, vecs[i].afull, vecs[i].ovf);
    end

    // Fill 0x00..0x0F: afull from the 12th push, full at the 16th.
    drive(1, 1, 8'h00, 1, 0);
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 8'(i), 1, 0);
      check_all($sformatf("fill%0d", i), 8'h00, 5'(i + 1), 1'b0, (i + 1) == 16,
                (i + 1) >= 12, 1'b0);
    end

    // Push while full: dropped, overflow sticks; set wins over a same-cycle clear.
    drive(0, 0, 8'hFF, 1, 0);
    check_all("ovf_set", 8'h00, 5'd16, 1'b0, 1'b1, 1'b1, 1'b1);
    drive(0, 0, 8'hFF, 1, 1);
    check_all("ovf_prio", 8'h00, 5'd16, 1'b0, 1'b1, 1'b1, 1'b1);
    drive(0, 1, 8'h00, 1, 1);
    check_all("ovf_clr", 8'h00, 5'd16, 1'b0, 1'b1, 1'b1, 1'b0);

    // Push+pop while full: oldest out, 0xAA into the freed slot, no overflow.
    drive(0, 0, 8'hAA, 0, 0);
    check_all("full_pushpop", 8'h00, 5'd16, 1'b0, 1'b1, 1'b1, 1'b0);

    // Drain with the strobe held low: 0x01..0x0F then 0xAA across the wrap.
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp_d;
      exp_d = (i < 15) ? 8'(i + 1) : 8'hAA;
      drive(0, 1, 8'h00, 0, 0);
      check_all($sformatf("drain%0d", i), exp_d, 5'(15 - i), i == 15, 1'b0,
                (15 - i) >= 12, 1'b0);
    end
    drive(0, 1, 8'h00, 0, 0);
    check_all("drain_empty_pop", 8'hAA, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(0, 1, 8'h00, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
